// File: rtl/serial_pkg.sv
// serial_pkg: definitions shared by the serial bit source.
//   state_e    - FSM state encoding (2-bit): S_IDLE, S_SHIFT, S_GAP
//   cnt_width  - width of a counter that must hold values 0..w
package serial_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  // Smallest r such that 2**r > w, i.e. clog2(w+1).
  // The loop stops at 30 so the shift never reaches the sign bit.
  function automatic int cnt_width(input int w);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < (w + 1)) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/word_hold_buf.sv
// word_hold_buf: one-entry holding register for {data, msb_first} with a full flag.
//   clk_i   - clock, rising edge
//   rst_ni  - asynchronous reset, active low (empties the buffer)
//   push_i  - write data_i/msb_i and mark full
//   pop_i   - mark empty (the consumer reads data_o/msb_o in the same cycle)
//   data_i  - word to store
//   msb_i   - bit-order flag stored with the word
//   full_o  - buffer holds a word
//   data_o  - stored word
//   msb_o   - stored bit-order flag
module word_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             msb_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o,
  output logic             msb_o
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             msb_q, msb_d;

  // Next-state: a push wins over a pop so a same-edge pop/push keeps the new word.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    msb_d  = msb_q;
    if (push_i) begin
      full_d = 1'b1;
      data_d = data_i;
      msb_d  = msb_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  // Storage registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
      msb_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      msb_q  <= msb_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;
  assign msb_o  = msb_q;

endmodule

// File: rtl/serial_bit_source.sv
// serial_bit_source: accepts parallel words over valid/ready and shifts them out
// one bit per clock on x, with a one-entry holding buffer and an optional gap.
//   clk        - clock, rising edge
//   rst        - asynchronous reset, active low
//   din        - parallel word to serialize
//   din_valid  - din holds a word
//   din_ready  - a word can be taken this cycle (buffer not full)
//   msb_first  - bit order captured with each accepted word (1 = MSB first)
//   x          - registered serial bit
//   x_valid    - registered, x carries a data bit
//   word_done  - registered pulse while the last bit of a word is on x
//   busy       - shift in progress or a word is buffered
//   bit_cnt    - bits of the current word presented so far, including the current one
module serial_bit_source
  import serial_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter int   GAP      = 0,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              din,
  input  logic                          din_valid,
  output logic                          din_ready,
  input  logic                          msb_first,
  output logic                          x,
  output logic                          x_valid,
  output logic                          word_done,
  output logic                          busy,
  output logic [cnt_width(WIDTH)-1:0]   bit_cnt
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] WIDTH_C  = CW'(WIDTH);
  localparam logic          HAS_GAP  = (GAP > 0);
  localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             msb_q, msb_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             word_done_q, word_done_d;

  logic             hold_full_s, hold_msb_s;
  logic [WIDTH-1:0] hold_data_s;
  logic             accept_s, push_s, pop_s;
  logic             reload_s, load_s, load_din_s;
  logic [WIDTH-1:0] src_word_s;
  logic             src_msb_s;

  assign din_ready = ~hold_full_s;
  assign accept_s  = din_valid & ~hold_full_s;
  // A word taken straight into the shift register never touches the buffer.
  assign push_s    = accept_s & ~load_din_s;
  assign busy      = (state_q != S_IDLE) | hold_full_s;

  word_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk_i  (clk),
    .rst_ni (rst),
    .push_i (push_s),
    .pop_i  (pop_s),
    .data_i (din),
    .msb_i  (msb_first),
    .full_o (hold_full_s),
    .data_o (hold_data_s),
    .msb_o  (hold_msb_s)
  );

  // FSM next-state, shift/counter updates and next registered outputs.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    msb_d       = msb_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    x_d         = IDLE_BIT;
    x_valid_d   = 1'b0;
    word_done_d = 1'b0;
    reload_s    = 1'b0;
    load_s      = 1'b0;
    load_din_s  = 1'b0;
    pop_s       = 1'b0;
    src_word_s  = din;
    src_msb_s   = msb_first;

    case (state_q)
      S_IDLE: begin
        reload_s = 1'b1;
      end
      S_SHIFT: begin
        if (bit_cnt_q == WIDTH_C) begin
          if (HAS_GAP) begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_LAST;
            bit_cnt_d = '0;
          end else begin
            reload_s = 1'b1;
          end
        end else begin
          // The presented bit always sits at the MSB or LSB end of shreg.
          if (msb_q) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            x_d     = shreg_d[WIDTH-1];
          end else begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            x_d     = shreg_d[0];
          end
          bit_cnt_d   = bit_cnt_q + CW'(1);
          x_valid_d   = 1'b1;
          word_done_d = (bit_cnt_d == WIDTH_C);
        end
      end
      S_GAP: begin
        if (gap_cnt_q == 4'd0) begin
          reload_s = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        bit_cnt_d = '0;
      end
    endcase

    // Word boundary: the buffered word has priority; otherwise a word offered
    // now goes straight into the shift register so no bubble appears.
    if (reload_s) begin
      if (hold_full_s) begin
        pop_s      = 1'b1;
        load_s     = 1'b1;
        src_word_s = hold_data_s;
        src_msb_s  = hold_msb_s;
      end else if (accept_s) begin
        load_din_s = 1'b1;
        load_s     = 1'b1;
      end else begin
        state_d   = S_IDLE;
        bit_cnt_d = '0;
      end
    end else begin
      load_s = 1'b0;
    end

    if (load_s) begin
      state_d     = S_SHIFT;
      shreg_d     = src_word_s;
      msb_d       = src_msb_s;
      bit_cnt_d   = CW'(1);
      x_valid_d   = 1'b1;
      x_d         = src_msb_s ? src_word_s[WIDTH-1] : src_word_s[0];
      word_done_d = 1'b0;
    end else begin
      msb_d = msb_d;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      msb_q       <= 1'b0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= 4'd0;
      x_q         <= IDLE_BIT;
      x_valid_q   <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      msb_q       <= msb_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      x_q         <= x_d;
      x_valid_q   <= x_valid_d;
      word_done_q <= word_done_d;
    end
  end

  assign x         = x_q;
  assign x_valid   = x_valid_q;
  assign word_done = word_done_q;
  assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_serial_bit_source.sv
// tb_serial_bit_source: scoreboard bench. Two instances (GAP=0 and GAP=3) share
// clock and reset; expected bits are queued on each accept and compared as
// they appear on x.
module tb_serial_bit_source;

  localparam int W  = 8;
  localparam int CW = 4;

  typedef struct packed {
    logic          x;
    logic [CW-1:0] cnt;
    logic          wd;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  din0 = '0, din1 = '0;
  logic          dv0 = 1'b0, dv1 = 1'b0, msb0 = 1'b0, msb1 = 1'b0;
  logic          rdy0, x0, xv0, wd0, busy0;
  logic          rdy1, x1, xv1, wd1, busy1;
  logic [CW-1:0] cnt0, cnt1;

  exp_t exp0[$];
  exp_t exp1[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc = 0;
  int   idle_run[2];
  int   last_gap[2];
  int   last_wd_cyc[2];

  serial_bit_source #(.WIDTH(W), .GAP(0), .IDLE_BIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .din(din0), .din_valid(dv0), .din_ready(rdy0),
    .msb_first(msb0), .x(x0), .x_valid(xv0), .word_done(wd0), .busy(busy0),
    .bit_cnt(cnt0)
  );

  serial_bit_source #(.WIDTH(W), .GAP(3), .IDLE_BIT(1'b0)) dut1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(dv1), .din_ready(rdy1),
    .msb_first(msb1), .x(x1), .x_valid(xv1), .word_done(wd1), .busy(busy1),
    .bit_cnt(cnt1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", tag, obs, exp);
    end
  endtask

  // Queue the 8 expected output beats of one accepted word.
  task automatic push_word(input int d, input logic [W-1:0] w, input logic m);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      e.x   = m ? w[W-1-i] : w[i];
      e.cnt = CW'(i + 1);
      e.wd  = (i == W - 1);
      if (d == 0) exp0.push_back(e);
      else        exp1.push_back(e);
    end
  endtask

  // One monitor beat for instance d.
  task automatic mon_step(input int d, input logic xv, input logic xb,
                          input logic wd, input logic [CW-1:0] cnt);
    exp_t e;
    int   sz;
    sz = (d == 0) ? exp0.size() : exp1.size();
    if (xv) begin
      if (sz == 0) begin
        check_val($sformatf("dut%0d_unexpected_bit", d), 32'(xv), 32'd0);
      end else begin
        if (d == 0) e = exp0.pop_front();
        else        e = exp1.pop_front();
        check_val($sformatf("dut%0d_x", d), 32'(xb), 32'(e.x));
        check_val($sformatf("dut%0d_bit_cnt", d), 32'(cnt), 32'(e.cnt));
        check_val($sformatf("dut%0d_word_done", d), 32'(wd), 32'(e.wd));
        if (cnt == CW'(1)) last_gap[d] = idle_run[d];
        if (wd) last_wd_cyc[d] = cyc;
      end
      idle_run[d] = 0;
    end else begin
      check_val($sformatf("dut%0d_idle_x", d), 32'(xb), 32'd0);
      check_val($sformatf("dut%0d_idle_cnt", d), 32'(cnt), 32'd0);
      check_val($sformatf("dut%0d_idle_wd", d), 32'(wd), 32'd0);
      idle_run[d] = idle_run[d] + 1;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon_step(0, xv0, x0, wd0, cnt0);
      mon_step(1, xv1, x1, wd1, cnt1);
    end
  end

  // Offer a word and hold it until accepted; din_valid stays high afterwards.
  task automatic send(input int d, input logic [W-1:0] w, input logic m, output int acc_cyc);
    logic done;
    done = 1'b0;
    acc_cyc = -1;
    @(negedge clk);
    if (d == 0) begin din0 = w; msb0 = m; dv0 = 1'b1; end
    else        begin din1 = w; msb1 = m; dv1 = 1'b1; end
    for (int t = 0; t < 100 && !done; t++) begin
      if (t > 0) @(negedge clk);
      if (((d == 0) ? rdy0 : rdy1) == 1'b1) begin
        push_word(d, w, m);
        acc_cyc = cyc;
        @(posedge clk);
        done = 1'b1;
      end
    end
    check_val($sformatf("dut%0d_accept_in_time", d), 32'(done), 32'd1);
  endtask

  task automatic idle_in(input int d);
    #1;
    if (d == 0) dv0 = 1'b0;
    else        dv1 = 1'b0;
  endtask

  // Wait (bounded) until every expected beat is out and the block is idle.
  task automatic wait_drain(input int d);
    int sz;
    logic b;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      #1;
      sz = (d == 0) ? exp0.size() : exp1.size();
      b  = (d == 0) ? busy0 : busy1;
      if (sz == 0 && !b) break;
    end
    check_val($sformatf("dut%0d_drain_left", d), 32'(sz), 32'd0);
    check_val($sformatf("dut%0d_drain_busy", d), 32'(b), 32'd0);
  endtask

  initial begin
    int a, b, c, wdc;
    logic hit;

    // Reset held low: everything idle.
    #50;
    check_val("rst_x", 32'(x0), 32'd0);
    check_val("rst_x_valid", 32'(xv0), 32'd0);
    check_val("rst_din_ready", 32'(rdy0), 32'd1);
    check_val("rst_busy", 32'(busy0), 32'd0);
    check_val("rst_bit_cnt", 32'(cnt0), 32'd0);
    check_val("rst_word_done", 32'(wd0), 32'd0);
    #50;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_val("post_rst_ready", 32'(rdy0), 32'd1);
    check_val("post_rst_busy", 32'(busy0), 32'd0);

    // Single word, MSB first then LSB first.
    send(0, 8'hB4, 1'b1, a);
    idle_in(0);
    wait_drain(0);
    send(0, 8'hB4, 1'b0, a);
    idle_in(0);
    wait_drain(0);

    // Back-to-back with GAP=0: second word waits in the buffer, no bubble.
    send(0, 8'hF0, 1'b1, a);
    send(0, 8'h0F, 1'b1, b);
    #1;
    check_val("b2b_ready_low_when_full", 32'(rdy0), 32'd0);
    check_val("b2b_busy", 32'(busy0), 32'd1);
    idle_in(0);
    wait_drain(0);
    check_val("b2b_no_bubble", 32'(last_gap[0]), 32'd0);

    // GAP=3 instance: exactly 3 idle cycles between the two words.
    send(1, 8'hA5, 1'b1, a);
    send(1, 8'h3C, 1'b0, b);
    idle_in(1);
    wait_drain(1);
    check_val("gap_len", 32'(last_gap[1]), 32'd3);

    // Backpressure: the third word is taken only the cycle after word_done.
    send(0, 8'h11, 1'b1, a);
    send(0, 8'h22, 1'b0, b);
    send(0, 8'hC3, 1'b1, c);
    wdc = last_wd_cyc[0];
    idle_in(0);
    check_val("bp_third_accept_cycle", 32'(c), 32'(wdc + 1));
    wait_drain(0);

    // Reset in the middle of a word: output drops at once and stays quiet.
    send(0, 8'h5A, 1'b1, a);
    idle_in(0);
    hit = 1'b0;
    for (int t = 0; t < 50 && !hit; t++) begin
      @(negedge clk);
      if (cnt0 == CW'(3)) hit = 1'b1;
    end
    check_val("midrst_reached_bit3", 32'(hit), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_val("midrst_x_valid", 32'(xv0), 32'd0);
    check_val("midrst_busy", 32'(busy0), 32'd0);
    check_val("midrst_ready", 32'(rdy0), 32'd1);
    check_val("midrst_bit_cnt", 32'(cnt0), 32'd0);
    exp0.delete();
    exp1.delete();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    check_val("midrst_quiet_x_valid", 32'(xv0), 32'd0);
    check_val("midrst_quiet_busy", 32'(busy0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/serial_bit_source.md
Name: serial_bit_source

Overview:
- Upstream feeder for the serial sequence-detector FSM.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on x, which drives the FSM's x input.
- One-entry holding buffer so the next word can queue while the current word shifts; configurable inter-word gap; word-complete pulse for the bench/sequencer.

Parameters:
- WIDTH, 8, bits per word (2..32)
- GAP, 0, idle cycles inserted between consecutive words (0..15); 0 = back-to-back
- IDLE_BIT, 0, value driven on x when no bit is valid

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low (asserted at 0)
- din  input  WIDTH  parallel word to serialize
- din_valid  input  1  din holds a word
- din_ready  output  1  block can take a word this cycle
- msb_first  input  1  bit order, sampled with each accepted word (1 = MSB first)
- x  output  1  serial bit to the FSM, registered
- x_valid  output  1  x carries a data bit this cycle, registered
- word_done  output  1  one-cycle pulse on the cycle the last bit of a word is on x
- busy  output  1  shift register or holding buffer occupied
- bit_cnt  output  $clog2(WIDTH+1)  bits of the current word already presented, including the current one

Behaviour:
- Reset (rst=0, async), all outputs: x=IDLE_BIT, x_valid=0, word_done=0, busy=0, bit_cnt=0, din_ready=1; holding buffer empty; state IDLE. Reset mid-word drops the word and the buffered word with no partial output afterwards.
- Handshake: a word is accepted at the rising edge where din_valid&&din_ready. din_ready = !hold_full (combinational from the register). din/msb_first are captured together.
- States:
  - IDLE: accept goes straight to SHIFT, loads the shift register, and drives the first bit on x at the same edge (latency: the bit is visible in the cycle after the accept edge).
  - SHIFT: present one bit per cycle for WIDTH cycles with x_valid=1; bit_cnt goes 1..WIDTH. On the cycle bit_cnt==WIDTH, word_done=1. At the next edge:
    - if GAP>0, go to GAP;
    - else if a word is buffered (or one is accepted at this same edge into an empty buffer while in IDLE-equivalent, see below), load it and stay in SHIFT with bit_cnt=1;
    - else go to IDLE.
  - GAP: x=IDLE_BIT, x_valid=0, bit_cnt=0 for exactly GAP cycles (gap counter). Then:
    - if a word is buffered, load it and go to SHIFT;
    - else go to IDLE.
- Holding buffer: while SHIFT or GAP, an accepted word goes to the holding buffer, and din_ready drops the next cycle.
- Simultaneous events:
  - Buffer drained to the shift register at the same edge a new word is offered: din_ready was 0, so no accept that cycle; it is accepted next cycle.
  - Word accepted at the last-bit edge with the buffer empty and GAP=0: the new word goes directly to the shift register with no bubble (x_valid stays 1).
- Bit order is LSB-first when msb_first=0; bit order is per-word and never changes mid-word.
- busy = (state!=IDLE) || hold_full.
- In IDLE: x=IDLE_BIT, x_valid=0, bit_cnt=0.
- The counter saturates only through reload; no wrap beyond WIDTH.

Decomposition:
- Shared package serial_pkg:
  - state encoding constants S_IDLE, S_SHIFT, S_GAP (2-bit);
  - a function for counter width (clog2).
- One sub-module: word_hold_buf, a single-entry register with {WIDTH data, msb_first} plus a full flag, and push/pop ports.
- The top holds the FSM, shift register, bit counter and gap counter.

Test Plan:
- Reset value: rst=0 for 100 ns then 1 → x=0, x_valid=0, din_ready=1, busy=0. Assert rst=0 mid-word at bit 3 → x_valid=0 immediately (async); nothing is output after release until a new accept.
- Single word: WIDTH=8, din=8'hB4, msb_first=1 → x=1,0,1,1,0,1,0,0 on 8 consecutive cycles, x_valid=1, bit_cnt 1..8, word_done on the 8th cycle only, then IDLE.
- LSB-first: din=8'hB4, msb_first=0 → x=0,0,1,0,1,1,0,1.
- Back-to-back, GAP=0: 8'hF0 then 8'h0F with din_valid held → 16 contiguous valid bits 11110000 00001111, no x_valid bubble; din_ready low while the buffer is full.
- Gap: GAP=3, two words → exactly 3 cycles with x_valid=0 and x=IDLE_BIT between word_done and the first bit of word 2.
- Backpressure: hold din_valid=1 with 3 words queued → the third word is accepted only after the first word_done edge. No word is lost or duplicated, checked by a scoreboard comparing the serial stream to the accepted words.
